// File: rtl/ber_seq_ctrl.sv
// rtl/ber_seq_ctrl.sv - run sequencer for the QPSK receiver BER checker
module ber_seq_ctrl #(
  parameter int CLR_CYCLES   = 4,
  parameter int SETTLE_TICKS = 262144,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] window_len,
  input  logic             valid_in,
  input  logic             err_in,
  output logic             ber_rst_n,
  output logic             ber_enable,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] err_count,
  output logic             err_sat
);

  localparam int CLR_W  = $clog2(CLR_CYCLES + 1);
  localparam int TICK_W = $clog2(SETTLE_TICKS + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_SETTLE  = 3'd2,
    S_MEASURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CLR_W-1:0]   clr_cnt;
  logic [TICK_W-1:0]  tick_cnt;
  logic [CNT_W-1:0]   win_len;
  logic [CNT_W-1:0]   bit_next;
  logic [CNT_W-1:0]   err_next;
  logic               start_acc;
  logic               settle_inc;
  logic               meas_tick;

  // Next counter values for a measured tick; errors stop at all-ones
  always_comb begin
    bit_next = bit_count + CNT_W'(1);
    err_next = err_count;
    if (err_in && !(&err_count)) begin
      err_next = err_count + CNT_W'(1);
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort outranks everything while a run is active
  always_comb begin
    state_d    = state_q;
    start_acc  = 1'b0;
    settle_inc = 1'b0;
    meas_tick  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_CLEAR;
          start_acc = 1'b1;
        end
      end
      S_CLEAR: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (clr_cnt == CLR_W'(CLR_CYCLES - 1)) begin
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (valid_in) begin
          settle_inc = 1'b1;
          if (tick_cnt == TICK_W'(SETTLE_TICKS - 1)) begin
            state_d = S_MEASURE;
          end
        end
      end
      S_MEASURE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (bit_count == win_len) begin
          // Only reachable with a zero-length window: leave without counting
          state_d = S_DONE;
        end else if (valid_in) begin
          meas_tick = 1'b1;
          if (bit_next == win_len) begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status decode and checker enable gating
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    ber_enable = 1'b0;
    if (state_q == S_CLEAR || state_q == S_SETTLE || state_q == S_MEASURE) begin
      busy = 1'b1;
    end
    if (state_q == S_DONE) begin
      done = 1'b1;
    end
    if (state_q == S_SETTLE || state_q == S_MEASURE) begin
      ber_enable = valid_in;
    end
  end

  // Checker reset is low for exactly the cycles spent in CLEAR
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ber_rst_n <= 1'b0;
    end else begin
      ber_rst_n <= (state_d != S_CLEAR);
    end
  end

  // Run counters: cleared on accepted start, frozen on abort
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_cnt   <= '0;
      tick_cnt  <= '0;
      win_len   <= '0;
      bit_count <= '0;
      err_count <= '0;
      err_sat   <= 1'b0;
    end else if (start_acc) begin
      clr_cnt   <= '0;
      tick_cnt  <= '0;
      win_len   <= window_len;
      bit_count <= '0;
      err_count <= '0;
      err_sat   <= 1'b0;
    end else begin
      if (state_q == S_CLEAR) begin
        clr_cnt <= clr_cnt + CLR_W'(1);
      end
      if (settle_inc) begin
        tick_cnt <= tick_cnt + TICK_W'(1);
      end
      if (meas_tick) begin
        bit_count <= bit_next;
        err_count <= err_next;
        if (&err_next) begin
          err_sat <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ber_seq_ctrl.sv
// tb/tb_ber_seq_ctrl.sv - scoreboard bench for ber_seq_ctrl
module tb_ber_seq_ctrl;

  typedef struct {
    logic [31:0] bits;
    logic [31:0] errs;
    logic        sat;
    int          dcyc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start_a;
  logic        start_b;
  logic        abort;
  logic        valid_in;
  logic        err_in;
  logic [31:0] window_len_a;
  logic [3:0]  window_len_b;

  logic        ber_rst_n_a, ber_enable_a, busy_a, done_a, err_sat_a;
  logic [31:0] bit_count_a, err_count_a;
  logic        ber_rst_n_b, ber_enable_b, busy_b, done_b, err_sat_b;
  logic [3:0]  bit_count_b, err_count_b;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   vmode = 1;
  int   emode = 0;
  int   phase = 0;
  int   vtick = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  logic done_a_q = 1'b0;
  logic done_b_q = 1'b0;

  ber_seq_ctrl #(.CLR_CYCLES(4), .SETTLE_TICKS(16), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort),
    .window_len(window_len_a), .valid_in(valid_in), .err_in(err_in),
    .ber_rst_n(ber_rst_n_a), .ber_enable(ber_enable_a), .busy(busy_a), .done(done_a),
    .bit_count(bit_count_a), .err_count(err_count_a), .err_sat(err_sat_a)
  );

  ber_seq_ctrl #(.CLR_CYCLES(4), .SETTLE_TICKS(16), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort),
    .window_len(window_len_b), .valid_in(valid_in), .err_in(err_in),
    .ber_rst_n(ber_rst_n_b), .ber_enable(ber_enable_b), .busy(busy_b), .done(done_b),
    .bit_count(bit_count_b), .err_count(err_count_b), .err_sat(err_sat_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive inputs 1ns after the edge, return at the sample point 2ns after
  task automatic step();
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    abort   = 1'b0;
    phase++;
    case (vmode)
      0: valid_in = 1'b0;
      1: valid_in = 1'b1;
      default: valid_in = (phase % 3 == 0);
    endcase
    if (valid_in) vtick++;
    case (emode)
      0: err_in = 1'b0;
      1: err_in = valid_in && (vtick % 10 == 0);
      default: err_in = valid_in;
    endcase
    #1;
  endtask

  task automatic wait_done_a(input string name, input int max);
    int n = 0;
    while (!done_a && n < max) begin
      step();
      n++;
    end
    check(name, done_a, 1);
    step();
  endtask

  task automatic push_a(input int bits, input int errs, input logic sat, input int dcyc);
    exp_t e;
    e.bits = bits; e.errs = errs; e.sat = sat; e.dcyc = dcyc;
    q_a.push_back(e);
  endtask

  // Monitor: every rising done pops the next expected result for that instance
  always @(negedge clk) begin
    if (done_a && !done_a_q) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_done", 1, 0);
      end else begin
        ea = q_a.pop_front();
        check("a_bit_count", bit_count_a, ea.bits);
        check("a_err_count", err_count_a, ea.errs);
        check("a_err_sat", err_sat_a, ea.sat);
        check("a_busy_at_done", busy_a, 0);
        if (ea.dcyc != 0) check("a_done_cycle", cyc, ea.dcyc);
      end
    end
    if (done_b && !done_b_q) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_done", 1, 0);
      end else begin
        eb = q_b.pop_front();
        check("b_bit_count", bit_count_b, eb.bits);
        check("b_err_count", err_count_b, eb.errs);
        check("b_err_sat", err_sat_b, eb.sat);
        if (eb.dcyc != 0) check("b_done_cycle", cyc, eb.dcyc);
      end
    end
    done_a_q = done_a;
    done_b_q = done_b;
  end

  initial begin
    int lowcnt, pulses, bad, n;
    reset = 1'b1; start_a = 0; start_b = 0; abort = 0;
    valid_in = 1'b1; err_in = 1'b0;
    window_len_a = '0; window_len_b = '0;
    repeat (3) step();
    check("rst_ber_rst_n", ber_rst_n_a, 0);
    check("rst_ber_enable", ber_enable_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_bit_count", bit_count_a, 0);
    check("rst_err_count", err_count_a, 0);
    check("rst_err_sat", err_sat_a, 0);
    reset = 1'b0;
    step();
    check("idle_ber_rst_n", ber_rst_n_a, 1);
    check("idle_ber_enable", ber_enable_a, 0);

    // Clean run: window 100, valid every clock
    vmode = 1; emode = 0;
    window_len_a = 100; start_a = 1'b1;
    push_a(100, 0, 0, cyc + 121);
    step();
    check("clean_busy", busy_a, 1);
    lowcnt = 0;
    if (!ber_rst_n_a) lowcnt++;
    repeat (9) begin
      step();
      if (!ber_rst_n_a) lowcnt++;
    end
    check("clean_rst_low_cycles", lowcnt, 4);
    wait_done_a("clean_timeout", 300);

    // Errors with gaps: valid every 3rd clock, error on every 10th tick
    vmode = 0; emode = 1;
    window_len_a = 50; start_a = 1'b1;
    push_a(50, 5, 0, 0);
    pulses = 0; bad = 0; n = 0;
    step();
    while (!ber_rst_n_a && n < 20) begin step(); n++; end
    vmode = 2; phase = 0; vtick = 0;
    n = 0;
    while (!done_a && n < 400) begin
      step();
      if (ber_enable_a) pulses++;
      if (ber_enable_a && !valid_in) bad++;
      n++;
    end
    check("gaps_timeout", done_a, 1);
    check("gaps_enable_pulses", pulses, 66);
    check("gaps_enable_without_valid", bad, 0);
    step();

    // Saturation on the 4-bit instance
    vmode = 1; emode = 2;
    window_len_b = 15; start_b = 1'b1;
    begin
      exp_t e;
      e.bits = 15; e.errs = 15; e.sat = 1'b1; e.dcyc = cyc + 36;
      q_b.push_back(e);
    end
    n = 0;
    step();
    while (!done_b && n < 100) begin step(); n++; end
    check("sat_timeout", done_b, 1);
    step();

    // Abort in MEASURE after 20 bits, then rerun
    vmode = 1; emode = 0;
    window_len_a = 100; start_a = 1'b1;
    n = 0;
    step();
    while (bit_count_a != 20 && n < 100) begin step(); n++; end
    abort = 1'b1;
    step();
    check("abort_busy", busy_a, 0);
    check("abort_done", done_a, 0);
    check("abort_bits_held", bit_count_a, 20);
    repeat (3) step();
    check("abort_bits_still_held", bit_count_a, 20);
    window_len_a = 30; start_a = 1'b1;
    push_a(30, 0, 0, cyc + 51);
    step();
    check("rerun_bits_cleared", bit_count_a, 0);
    wait_done_a("rerun_timeout", 200);

    // Zero-length window
    window_len_a = 0; start_a = 1'b1;
    push_a(0, 0, 0, cyc + 22);
    step();
    wait_done_a("zero_timeout", 100);

    // Start while busy is ignored, including the new window_len
    window_len_a = 40; start_a = 1'b1;
    push_a(40, 0, 0, cyc + 61);
    repeat (8) step();
    window_len_a = 5; start_a = 1'b1;
    step();
    wait_done_a("busy_start_timeout", 200);

    // Start and abort together in SETTLE
    window_len_a = 10; start_a = 1'b1;
    repeat (8) step();
    start_a = 1'b1; abort = 1'b1;
    step();
    check("start_abort_busy", busy_a, 0);
    check("start_abort_done", done_a, 0);
    repeat (30) step();
    check("start_abort_stays_idle", busy_a, 0);

    // Asynchronous reset during SETTLE
    window_len_a = 10; start_a = 1'b1;
    repeat (8) step();
    check("pre_reset_settle", ber_rst_n_a && busy_a && ber_enable_a, 1);
    reset = 1'b1;
    #1;
    check("async_ber_rst_n", ber_rst_n_a, 0);
    check("async_busy", busy_a, 0);
    check("async_ber_enable", ber_enable_a, 0);
    check("async_done", done_a, 0);
    step();
    reset = 1'b0;
    repeat (30) step();

    check("a_queue_empty", q_a.size(), 0);
    check("b_queue_empty", q_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ber_seq_ctrl.md
# ber_seq_ctrl

Sequencer for one BER measurement run on the QPSK receiver's BER checker. On a start request it pulses the checker's active-low reset, gates the checker's enable through the checker's shift-alignment phase, then counts bits and errors over a programmable window and holds the result for readout. Sits between the control/register interface and the BER checker, driven by the symbol-rate tick of the receive datapath.

## Interface
- CLR_CYCLES, default 4: clocks the checker reset is held low per run; must be at least 1.
- SETTLE_TICKS, default 262144: valid ticks allowed for checker alignment (covers (511+1)^2 for a 511-bit sequence).
- CNT_W, default 32: width of the bit and error counters.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a run. Honoured in IDLE and DONE only.
- abort  in  1  one-cycle request to end a run early. Honoured in CLEAR, SETTLE and MEASURE.
- window_len  in  CNT_W  number of bits to measure. Latched on an accepted start.
- valid_in  in  1  symbol-rate tick from the datapath.
- err_in  in  1  per-bit error from the checker's aligned comparison. Qualified by valid_in.
- ber_rst_n  out  1  active-low reset to the BER checker.
- ber_enable  out  1  enable to the BER checker.
- busy  out  1  high in CLEAR, SETTLE and MEASURE.
- done  out  1  high in DONE.
- bit_count  out  CNT_W  bits counted in the current or last window.
- err_count  out  CNT_W  errors counted. Saturates.
- err_sat  out  1  sticky: err_count reached all-ones.

## Operation
- States and transitions:
  - IDLE: start → CLEAR.
  - CLEAR: after CLR_CYCLES clocks → SETTLE.
  - SETTLE: after SETTLE_TICKS valid ticks → MEASURE.
  - MEASURE: when bit_count reaches window_len → DONE.
  - DONE: start → CLEAR.
  - abort from CLEAR, SETTLE or MEASURE → IDLE.
- Accepted start:
  - latches window_len;
  - clears bit_count, err_count, err_sat and the internal counters on entry to CLEAR.
- ber_rst_n is registered:
  - 0 in reset and in CLEAR;
  - 1 otherwise.
- ber_enable is combinational: valid_in AND (state is SETTLE or MEASURE). It is 0 in IDLE, CLEAR and DONE.
- SETTLE keeps a tick counter of width clog2(SETTLE_TICKS+1). It increments on valid_in. The tick that makes it equal to SETTLE_TICKS moves the state to MEASURE on the next clock. That tick is not counted as a measured bit.
- MEASURE, on each valid_in:
  - bit_count += 1;
  - if err_in = 1: err_count += 1, unless err_count is all-ones;
  - if err_count is all-ones after the update: err_sat = 1.
- Window end: the valid_in that makes bit_count equal to the latched window_len moves the state to DONE on the next clock.
- window_len = 0: MEASURE exits on the first clock with bit_count = 0 and err_count = 0. No tick is counted.
- abort: returns to IDLE with bit_count, err_count and err_sat frozen. done stays 0.
- start outside IDLE/DONE: ignored. abort in IDLE/DONE: ignored.
- start and abort in the same cycle:
  - in CLEAR, SETTLE or MEASURE, abort wins;
  - in IDLE or DONE, start wins.
- reset mid-run: state goes to IDLE. All counters and outputs go to their reset values.

## Timing
- Reset values: ber_rst_n=0, ber_enable=0, busy=0, done=0, bit_count=0, err_count=0, err_sat=0.
- start accepted in cycle t:
  - busy=1 and ber_rst_n=0 from t+1;
  - ber_rst_n=1 and state SETTLE from t+1+CLR_CYCLES.
- Counter and flag updates are visible the clock after the qualifying valid_in.
- The last MEASURE tick at cycle u gives done=1 and busy=0 at u+1. The final counts are valid at that same edge.
- done stays high until the next accepted start or reset. It drops the cycle after the start (state CLEAR).
- Back-to-back valid_in on every clock is supported. No throughput limit.

## Test plan
- Clean run: CLR_CYCLES=4, SETTLE_TICKS=16, window_len=100, valid_in every clock, err_in=0.
  → ber_rst_n low for exactly 4 cycles;
  → done 121 cycles after start, with bit_count=100, err_count=0.
- Errors with gaps: valid_in every 3rd clock, err_in=1 on every 10th valid tick, window_len=50.
  → err_count=5, bit_count=50;
  → ber_enable pulses only with valid_in.
- Saturation: CNT_W=4, err_in=1 on every tick, window_len=15.
  → err_count=15, err_sat=1, bit_count=15.
- Abort mid-MEASURE after 20 bits.
  → IDLE, done=0, bit_count=20 held;
  → a later start clears the counts and reruns.
- Edge cases:
  - window_len=0 → done with zero counts right after SETTLE;
  - start while busy → ignored;
  - start+abort together in SETTLE → IDLE.
- Asynchronous reset asserted during SETTLE.
  → all outputs at reset values immediately, without a clock edge.
